// File: rtl/jtag_ir_decode_if.sv
// jtag_ir_decode_if: TAP-side bundle between the TAP controller and the IR/decode block
interface jtag_ir_decode_if #(
  parameter int IR_LENGTH = 4,
  parameter int NUM_INSTR = 4
);
  logic                 tdi;
  logic                 state_test_logic_reset;
  logic                 state_capture_ir;
  logic                 state_shift_ir;
  logic                 state_update_ir;
  logic [IR_LENGTH-3:0] capture_status;
  logic                 serout;
  logic [IR_LENGTH-1:0] latched_jtag_ir;
  logic [NUM_INSTR-1:0] instr_sel;
  logic                 bypass_sel;
  logic                 update_pulse;
  logic                 ir_len_err;
  modport master (
    output tdi, state_test_logic_reset, state_capture_ir, state_shift_ir, state_update_ir, capture_status,
    input  serout, latched_jtag_ir, instr_sel, bypass_sel, update_pulse, ir_len_err
  );
  modport slave (
    input  tdi, state_test_logic_reset, state_capture_ir, state_shift_ir, state_update_ir, capture_status,
    output serout, latched_jtag_ir, instr_sel, bypass_sel, update_pulse, ir_len_err
  );
endinterface

// File: rtl/jtag_ir_decode.sv
// jtag_ir_decode: parametrised JTAG instruction register with registered one-hot decode
module jtag_ir_decode #(
  parameter int                               IR_LENGTH   = 4,
  parameter int                               NUM_INSTR   = 4,
  parameter logic [NUM_INSTR*IR_LENGTH-1:0]   INSTR_CODES = 16'h8320,
  parameter logic [IR_LENGTH-1:0]             RESET_INSTR = 4'b0010
) (
  input  logic             tck,
  input  logic             trst,
  jtag_ir_decode_if.slave  bus
);
  localparam int CW = $clog2(IR_LENGTH + 1);
  function automatic logic [NUM_INSTR-1:0] decode(input logic [IR_LENGTH-1:0] c);
    decode = '0;
    for (int k = NUM_INSTR - 1; k >= 0; k--)
      if (c == INSTR_CODES[k*IR_LENGTH +: IR_LENGTH]) decode = NUM_INSTR'(1) << k;
  endfunction
  logic [IR_LENGTH-1:0] jtag_ir_q, jtag_ir_d, latched_q, latched_d, upd_val;
  logic [NUM_INSTR-1:0] sel_q, sel_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 bypass_q, bypass_d, pulse_q, pulse_d, err_q, err_d, serout_q;
  logic                 tlr, cap, shift, upd, full, accept;
  assign tlr     = bus.state_test_logic_reset;
  assign cap     = bus.state_capture_ir;
  assign shift   = bus.state_shift_ir & ~cap;
  assign upd     = bus.state_update_ir & ~cap & ~bus.state_shift_ir & ~tlr;
  assign full    = cnt_q == CW'(IR_LENGTH);
  assign accept  = upd & (cnt_q == '0 | full);
  assign upd_val = |decode(jtag_ir_q) ? jtag_ir_q : '1;
  always_comb begin
    jtag_ir_d = tlr ? '0 : cap ? {bus.capture_status, 2'b01} : shift ? {bus.tdi, jtag_ir_q[IR_LENGTH-1:1]} : jtag_ir_q;
    cnt_d     = tlr | cap ? '0 : shift & ~full ? cnt_q + 1'b1 : cnt_q;
    latched_d = tlr ? RESET_INSTR : accept ? upd_val : latched_q;
    sel_d     = tlr ? decode(RESET_INSTR) : accept ? (&upd_val ? '0 : decode(upd_val)) : sel_q;
    bypass_d  = tlr ? 1'b0 : accept ? &upd_val : bypass_q;
    pulse_d   = accept;
    err_d     = ~tlr & (err_q | (upd & ~accept));
  end
  always_ff @(posedge tck) begin
    if (trst) begin
      jtag_ir_q <= '0;
      cnt_q     <= '0;
      latched_q <= RESET_INSTR;
      sel_q     <= decode(RESET_INSTR);
      bypass_q  <= 1'b0;
      pulse_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      jtag_ir_q <= jtag_ir_d;
      cnt_q     <= cnt_d;
      latched_q <= latched_d;
      sel_q     <= sel_d;
      bypass_q  <= bypass_d;
      pulse_q   <= pulse_d;
      err_q     <= err_d;
    end
  end
  // TDO-side output must only change on the falling edge
  always_ff @(negedge tck) serout_q <= trst ? 1'b0 : jtag_ir_q[0];
  assign bus.serout          = serout_q;
  assign bus.latched_jtag_ir = latched_q;
  assign bus.instr_sel       = sel_q;
  assign bus.bypass_sel      = bypass_q;
  assign bus.update_pulse    = pulse_q;
  assign bus.ir_len_err      = err_q;
endmodule

// File: tb/tb_jtag_ir_decode.sv
// tb_jtag_ir_decode: directed scans checked against an opcode-table model every cycle
module tb_jtag_ir_decode;
  logic tck = 1'b0, trst = 1'b1;
  int checks = 0, errors = 0;
  jtag_ir_decode_if #(.IR_LENGTH(4), .NUM_INSTR(4)) bus ();
  jtag_ir_decode dut (.tck(tck), .trst(trst), .bus(bus));
  always #5 tck = ~tck;

  int codes[4] = '{0, 2, 3, 8};
  logic [3:0] m_ir, m_lat;
  int m_cnt;
  bit m_err, m_pulse, m_ser, armed;

  function automatic int lookup(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (codes[i] == int'(v)) return i;
    return -1;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(posedge tck) begin
    m_pulse = 0;
    if (trst || bus.state_test_logic_reset) begin
      m_ir = 0; m_lat = 4'b0010; m_err = 0; m_cnt = 0; armed = 1;
    end else if (bus.state_capture_ir) begin
      m_ir = {bus.capture_status, 2'b01}; m_cnt = 0;
    end else if (bus.state_shift_ir) begin
      m_ir = (m_ir >> 1) | (4'(bus.tdi) << 3);
      m_cnt = (m_cnt + 1 > 4) ? 4 : m_cnt + 1;
    end else if (bus.state_update_ir) begin
      if (m_cnt == 0 || m_cnt == 4) begin
        m_lat = lookup(m_ir) >= 0 ? m_ir : 4'hF;
        m_pulse = 1;
      end else m_err = 1;
    end
  end

  always @(negedge tck) begin
    int idx;
    m_ser = trst ? 1'b0 : m_ir[0];
    #1;
    if (armed) begin
      idx = lookup(m_lat);
      chk("m_latched", 32'(bus.latched_jtag_ir), 32'(m_lat));
      chk("m_instr_sel", 32'(bus.instr_sel), (m_lat == 4'hF || idx < 0) ? 32'd0 : 32'd1 << idx);
      chk("m_bypass", 32'(bus.bypass_sel), 32'(m_lat == 4'hF));
      chk("m_pulse", 32'(bus.update_pulse), 32'(m_pulse));
      chk("m_err", 32'(bus.ir_len_err), 32'(m_err));
      chk("m_serout", 32'(bus.serout), 32'(m_ser));
    end
  end

  task automatic step(input bit r, input bit tl, input bit c, input bit s, input bit u, input bit d);
    trst = r; bus.state_test_logic_reset = tl; bus.state_capture_ir = c;
    bus.state_shift_ir = s; bus.state_update_ir = u; bus.tdi = d;
    @(posedge tck); #3;
  endtask

  task automatic shift_bits(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, bits[i]);
  endtask

  initial begin
    logic [3:0] ser_exp;
    bus.capture_status = 2'b10;
    bus.tdi = 0; bus.state_test_logic_reset = 0; bus.state_capture_ir = 0;
    bus.state_shift_ir = 0; bus.state_update_ir = 0;
    step(1, 0, 0, 0, 0, 0);
    chk("rst_latched", 32'(bus.latched_jtag_ir), 32'h2);
    chk("rst_sel", 32'(bus.instr_sel), 32'h2);
    chk("rst_bypass", 32'(bus.bypass_sel), 32'h0);
    chk("rst_err", 32'(bus.ir_len_err), 32'h0);
    chk("rst_serout", 32'(bus.serout), 32'h0);
    step(0, 0, 1, 0, 0, 0);
    ser_exp = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0, i < 2);
      chk("t2_serout", 32'(bus.serout), 32'(ser_exp[i]));
    end
    step(0, 0, 0, 0, 1, 0);
    chk("t2_latched", 32'(bus.latched_jtag_ir), 32'h3);
    chk("t2_sel", 32'(bus.instr_sel), 32'h4);
    chk("t2_pulse", 32'(bus.update_pulse), 32'h1);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_pulse_end", 32'(bus.update_pulse), 32'h0);
    step(0, 0, 1, 0, 0, 0);
    shift_bits(8'b0101, 4);
    step(0, 0, 0, 0, 1, 0);
    chk("t3_latched", 32'(bus.latched_jtag_ir), 32'hF);
    chk("t3_bypass", 32'(bus.bypass_sel), 32'h1);
    chk("t3_sel", 32'(bus.instr_sel), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    shift_bits(8'b11, 2);
    step(0, 0, 0, 0, 1, 0);
    chk("t4_latched", 32'(bus.latched_jtag_ir), 32'hF);
    chk("t4_err", 32'(bus.ir_len_err), 32'h1);
    chk("t4_pulse", 32'(bus.update_pulse), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_err_sticky", 32'(bus.ir_len_err), 32'h1);
    step(0, 1, 0, 0, 0, 0);
    chk("t4_tlr_err", 32'(bus.ir_len_err), 32'h0);
    chk("t4_tlr_latched", 32'(bus.latched_jtag_ir), 32'h2);
    step(0, 0, 1, 0, 0, 0);
    shift_bits(8'b100011, 6);
    step(0, 0, 0, 0, 1, 0);
    chk("t5_latched", 32'(bus.latched_jtag_ir), 32'h8);
    chk("t5_sel", 32'(bus.instr_sel), 32'h8);
    chk("t5_err", 32'(bus.ir_len_err), 32'h0);
    step(0, 0, 1, 0, 1, 0);
    chk("t6_cap_wins", 32'(bus.latched_jtag_ir), 32'h8);
    chk("t6_no_pulse", 32'(bus.update_pulse), 32'h0);
    shift_bits(8'b11, 2);
    step(1, 0, 0, 0, 0, 0);
    chk("t6_rst_latched", 32'(bus.latched_jtag_ir), 32'h2);
    step(0, 0, 0, 0, 1, 0);
    chk("t6_zero_latched", 32'(bus.latched_jtag_ir), 32'h0);
    chk("t6_zero_sel", 32'(bus.instr_sel), 32'h1);
    chk("t6_zero_pulse", 32'(bus.update_pulse), 32'h1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
